// File: rtl/board_pkg.sv
// Shared definitions for the board state engine: cell codes, FSM states,
// and the mapping from (line, position-on-line) to a flat cell index.
package board_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_COMP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lines are numbered rows 0..n-1, columns n..2n-1, main diagonal 2n and
  // anti-diagonal 2n+1; k walks along the line from row 0 downwards.
  function automatic int line_cell(input int line, input int k, input int n);
    int idx;
    if (line < n) begin
      idx = line * n + k;
    end else if (line < 2 * n) begin
      idx = k * n + (line - n);
    end else if (line == 2 * n) begin
      idx = k * n + k;
    end else begin
      idx = k * n + (n - 1 - k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/board_line_match.sv
// Combinational line matcher: reports whether every cell on the selected
// line holds the given code. Line numbers past the last real line never match.
module board_line_match
  import board_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int LINE_W  = $clog2(2 * BOARD_N + 2)
) (
  input  logic [2*BOARD_N*BOARD_N-1:0] board_i,
  input  logic [LINE_W-1:0]            line_i,
  input  logic [1:0]                   code_i,
  output logic                         match_o
);

  localparam int NUM_CELLS = BOARD_N * BOARD_N;
  localparam int IDX_W     = $clog2(NUM_CELLS);
  localparam int NUM_LINES = 2 * BOARD_N + 2;

  logic [1:0]              cells [NUM_CELLS];
  logic [(1<<LINE_W)-1:0]  line_hit;

  // Unpack the flat board into addressable cells.
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      cells[i] = board_i[2*i +: 2];
    end
  end

  // Evaluate every line in parallel; the scanner picks one per cycle.
  always_comb begin
    line_hit = '0;
    for (int l = 0; l < NUM_LINES; l++) begin
      line_hit[LINE_W'(l)] = 1'b1;
      for (int k = 0; k < BOARD_N; k++) begin
        if (cells[IDX_W'(line_cell(l, k, BOARD_N))] != code_i) begin
          line_hit[LINE_W'(l)] = 1'b0;
        end
      end
    end
  end

  assign match_o = line_hit[line_i];

endmodule

// File: rtl/board_state_engine.sv
// N x N board state engine: accepts one move per handshake, rejects illegal
// moves, then scans one line per cycle for a win by the last mover or a draw.
//
//   state | meaning
//   IDLE  | waiting for a move, move_ready high
//   SCAN  | checking line line_q for the latched mover
//   DONE  | win or draw reached, board frozen until clear/reset
module board_state_engine
  import board_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int IDX_W   = $clog2(BOARD_N * BOARD_N),
  parameter int CNT_W   = $clog2(BOARD_N * BOARD_N + 1),
  parameter int LINE_W  = $clog2(2 * BOARD_N + 2)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         move_valid,
  output logic                         move_ready,
  input  logic [IDX_W-1:0]             move_idx,
  input  logic [1:0]                   move_code,
  output logic                         accepted,
  output logic                         illegal,
  output logic [2*BOARD_N*BOARD_N-1:0] board,
  output logic [CNT_W-1:0]             fill_count,
  output logic                         game_over,
  output logic [1:0]                   winner,
  output logic                         scanning
);

  localparam int NUM_CELLS = BOARD_N * BOARD_N;
  localparam int LAST_LINE = 2 * BOARD_N + 1;

  state_t                  state_q, state_d;
  logic [2*NUM_CELLS-1:0]  board_q, board_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [1:0]              mover_q, mover_d;
  logic [1:0]              winner_q, winner_d;
  logic                    accepted_q, accepted_d;
  logic                    illegal_q, illegal_d;

  logic                    line_match;
  logic                    idx_in_range;
  logic                    code_ok;
  logic                    cell_free;
  logic                    move_legal;

  board_line_match #(
    .BOARD_N (BOARD_N),
    .LINE_W  (LINE_W)
  ) u_line_match (
    .board_i (board_q),
    .line_i  (line_q),
    .code_i  (mover_q),
    .match_o (line_match)
  );

  // Legality of the presented move against the current board.
  always_comb begin
    idx_in_range = ({1'b0, move_idx} < (IDX_W+1)'(NUM_CELLS));
    code_ok      = (move_code == CELL_PLAYER) || (move_code == CELL_COMP);
    cell_free    = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_idx == IDX_W'(i)) begin
        cell_free = (board_q[2*i +: 2] == CELL_EMPTY);
      end
    end
    move_legal = idx_in_range && code_ok && cell_free;
  end

  // Next-state and registered pulse logic; clear overrides any move.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    count_d    = count_q;
    line_d     = line_q;
    mover_d    = mover_q;
    winner_d   = winner_q;
    accepted_d = 1'b0;
    illegal_d  = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      board_d  = '0;
      count_d  = '0;
      line_d   = '0;
      mover_d  = CELL_EMPTY;
      winner_d = CELL_EMPTY;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            if (move_legal) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (move_idx == IDX_W'(i)) begin
                  board_d[2*i +: 2] = move_code;
                end
              end
              count_d    = count_q + CNT_W'(1);
              accepted_d = 1'b1;
              mover_d    = move_code;
              line_d     = '0;
              state_d    = SCAN;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end

        SCAN: begin
          if (line_match) begin
            winner_d = mover_q;
            state_d  = DONE;
          end else if (line_q == LINE_W'(LAST_LINE)) begin
            // The count already includes the move just scanned.
            state_d = (count_q == CNT_W'(NUM_CELLS)) ? DONE : IDLE;
          end else begin
            line_d = line_q + LINE_W'(1);
          end
        end

        DONE: begin
          if (move_valid) begin
            illegal_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      board_q    <= '0;
      count_q    <= '0;
      line_q     <= '0;
      mover_q    <= CELL_EMPTY;
      winner_q   <= CELL_EMPTY;
      accepted_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      count_q    <= count_d;
      line_q     <= line_d;
      mover_q    <= mover_d;
      winner_q   <= winner_d;
      accepted_q <= accepted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign move_ready = (state_q == IDLE);
  assign scanning   = (state_q == SCAN);
  assign game_over  = (state_q == DONE);
  assign accepted   = accepted_q;
  assign illegal    = illegal_q;
  assign board      = board_q;
  assign fill_count = count_q;
  assign winner     = winner_q;

endmodule
